// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Deframer states and the two prefix scan codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability filter for one PS/2 line.
// Output only moves after FILTER_LEN equal differing samples.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line};
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deframer, timeout, prefix decode
// and held-key tracking for a programmable key table.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200,
  parameter int NUM_KEYS    = 10,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES = {
    8'h23, 8'h1C, 8'h3E, 8'h3D, 8'h36,
    8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
  }
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kclk,
  input  logic                kdata,
  output logic                code_valid,
  output logic [7:0]          code,
  output logic                code_ext,
  output logic                code_break,
  output logic                frame_err,
  output logic [NUM_KEYS-1:0] key_held
);

  localparam int TIMEOUT_CYCLES =
    CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic kclk_f;
  logic kdata_f;
  logic kclk_q;
  logic fall;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .line (kclk),
    .level(kclk_f)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .line (kdata),
    .level(kdata_f)
  );

  assign fall = kclk_q & ~kclk_f;

  ps2_state_e state, state_d;
  logic [2:0]    cnt, cnt_d;
  logic [7:0]    data, data_d;
  logic          par, par_d;
  logic [TW-1:0] tmr;
  logic          timeout;
  logic          byte_done;
  logic          err;

  assign timeout = (state != IDLE) && !fall &&
                   (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_q <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      data   <= '0;
      par    <= 1'b0;
      tmr    <= '0;
    end else begin
      kclk_q <= kclk_f;
      state  <= state_d;
      cnt    <= cnt_d;
      data   <= data_d;
      par    <= par_d;
      if (fall || state == IDLE) tmr <= '0;
      else                       tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    data_d    = data;
    par_d     = par;
    byte_done = 1'b0;
    err       = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err     = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!kdata_f) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          data_d[cnt] = kdata_f;
          cnt_d       = cnt + 3'd1;
          if (cnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = kdata_f;
          state_d = STOP;
        end
        STOP: begin
          if (kdata_f && (^data ^ par)) byte_done = 1'b1;
          else                          err       = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic ext_pend, ext_d;
  logic brk_pend, brk_d;
  logic ev;

  always_comb begin
    ext_d = ext_pend;
    brk_d = brk_pend;
    ev    = 1'b0;
    priority case (1'b1)
      err: begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
      byte_done && data == PS2_EXT: ext_d = 1'b1;
      byte_done && data == PS2_BRK: brk_d = 1'b1;
      byte_done: begin
        ev    = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
      default: ;
    endcase
  end

  logic [NUM_KEYS-1:0] hit;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    assign hit[i] = ev && !ext_pend &&
                    (data == KEY_CODES[8*i +: 8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      code_valid <= 1'b0;
      code       <= '0;
      code_ext   <= 1'b0;
      code_break <= 1'b0;
      frame_err  <= 1'b0;
      key_held   <= '0;
    end else begin
      ext_pend   <= ext_d;
      brk_pend   <= brk_d;
      code_valid <= ev;
      frame_err  <= err;
      if (ev) begin
        code       <= data;
        code_ext   <= ext_pend;
        code_break <= brk_pend;
      end
      key_held <= (key_held & ~hit) |
                  (hit & {NUM_KEYS{!brk_pend}});
    end
  end

endmodule
